// File: rtl/onehot_hold_decoder.sv
// rtl/onehot_hold_decoder.sv - handshake binary-to-one-hot decoder with hold timer, chaser scan and encoded echo
module onehot_hold_decoder #(
  parameter int CODE_W      = 3,
  parameter int OUT_W       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int SCAN_DIV    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_in,
  output logic              code_ready,
  input  logic              mode_scan,
  output logic [OUT_W-1:0]  onehot_out,
  output logic [CODE_W-1:0] code_echo,
  output logic              busy,
  output logic              err
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [HCW-1:0]  HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
  localparam logic [SCW-1:0]  SCAN_LOAD = SCW'(SCAN_DIV - 1);
  localparam logic [CODE_W:0] OUT_W_C   = (CODE_W + 1)'(OUT_W);
  localparam logic [OUT_W-1:0] FIRST_BIT = {{(OUT_W - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t           state;
  logic [HCW-1:0]   hold_cnt;
  logic [SCW-1:0]   scan_cnt;
  logic [OUT_W-1:0] dec;
  logic             code_legal;

  // Decode only at OUT_W bits so out-of-range codes can never alias onto a legal line.
  always_comb begin
    dec = '0;
    for (int i = 0; i < OUT_W; i++) dec[i] = (code_in == CODE_W'(i));
  end

  assign code_legal = ({1'b0, code_in} < OUT_W_C);
  assign code_ready = (state == IDLE) && !rst;
  assign busy       = (state != IDLE);

  always_comb begin
    code_echo = '0;
    for (int i = 0; i < OUT_W; i++)
      if (onehot_out[i]) code_echo = code_echo | CODE_W'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      onehot_out <= '0;
      hold_cnt   <= '0;
      scan_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (code_valid) begin
            if (code_legal) begin
              onehot_out <= dec;
              hold_cnt   <= HOLD_LOAD;
              state      <= HOLD;
            end else begin
              err <= 1'b1;
            end
          end else if (mode_scan) begin
            onehot_out <= FIRST_BIT;
            scan_cnt   <= SCAN_LOAD;
            state      <= SCAN;
          end
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HCW'(1);
          end else begin
            onehot_out <= '0;
            state      <= IDLE;
          end
        end
        SCAN: begin
          if (!mode_scan) begin
            onehot_out <= '0;
            scan_cnt   <= '0;
            state      <= IDLE;
          end else if (scan_cnt != '0) begin
            scan_cnt <= scan_cnt - SCW'(1);
          end else begin
            onehot_out <= {onehot_out[OUT_W-2:0], onehot_out[OUT_W-1]};
            scan_cnt   <= SCAN_LOAD;
          end
        end
        default: begin
          onehot_out <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_hold_decoder.sv
// tb/tb_onehot_hold_decoder.sv - directed-vector bench for onehot_hold_decoder (8-wide and 6-wide instances)
module tb_onehot_hold_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       v8, ms8, v6, ms6;
  logic [2:0] c8, c6;
  logic       rdy8, busy8, err8, rdy6, busy6, err6;
  logic [7:0] oh8;
  logic [5:0] oh6;
  logic [2:0] ec8, ec6;

  int vectors = 0;
  int miscompares = 0;

  // {onehot, echo, busy, ready, err}
  wire [13:0] obs8 = {oh8, ec8, busy8, rdy8, err8};
  wire [11:0] obs6 = {oh6, ec6, busy6, rdy6, err6};

  always #5 clk = ~clk;

  onehot_hold_decoder u8 (
    .clk(clk), .rst(rst), .code_valid(v8), .code_in(c8), .code_ready(rdy8),
    .mode_scan(ms8), .onehot_out(oh8), .code_echo(ec8), .busy(busy8), .err(err8)
  );

  onehot_hold_decoder #(.OUT_W(6)) u6 (
    .clk(clk), .rst(rst), .code_valid(v6), .code_in(c6), .code_ready(rdy6),
    .mode_scan(ms6), .onehot_out(oh6), .code_echo(ec6), .busy(busy6), .err(err6)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; v8 = 0; ms8 = 0; c8 = 0; v6 = 0; ms6 = 0; c6 = 0;
    tick(); tick();
    vectors++;
    if (obs8 !== 14'h0) begin miscompares++; $display("FAIL reset8 got %h exp %h", obs8, 14'h0); end
    vectors++;
    if (obs6 !== 12'h0) begin miscompares++; $display("FAIL reset6 got %h exp %h", obs6, 12'h0); end
    rst = 1'b0;
    #1;
    vectors++;
    if (obs8 !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL reset_ready got %h exp %h", obs8, {8'h00, 3'd0, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_hold;
    c8 = 3'd5; v8 = 1'b1;
    tick(); v8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs8 !== {8'h20, 3'd5, 1'b1, 1'b0, 1'b0}) begin
        miscompares++; $display("FAIL hold5 cyc%0d got %h exp %h", k, obs8, {8'h20, 3'd5, 1'b1, 1'b0, 1'b0});
      end
      tick();
    end
    vectors++;
    if (obs8 !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL hold5_end got %h exp %h", obs8, {8'h00, 3'd0, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    c8 = 3'd2; v8 = 1'b1;
    tick(); c8 = 3'd7;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs8 !== {8'h04, 3'd2, 1'b1, 1'b0, 1'b0}) begin
        miscompares++; $display("FAIL b2b_hold2 cyc%0d got %h exp %h", k, obs8, {8'h04, 3'd2, 1'b1, 1'b0, 1'b0});
      end
      tick();
    end
    vectors++;
    if (obs8 !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL b2b_idle got %h exp %h", obs8, {8'h00, 3'd0, 1'b0, 1'b1, 1'b0});
    end
    tick(); v8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs8 !== {8'h80, 3'd7, 1'b1, 1'b0, 1'b0}) begin
        miscompares++; $display("FAIL b2b_hold7 cyc%0d got %h exp %h", k, obs8, {8'h80, 3'd7, 1'b1, 1'b0, 1'b0});
      end
      tick();
    end
    vectors++;
    if (oh8 !== 8'h00) begin miscompares++; $display("FAIL b2b_end got %h exp %h", oh8, 8'h00); end
  endtask

  task automatic test_scan;
    logic [7:0] e;
    ms8 = 1'b1;
    tick();
    // Nine steps: the ninth re-checks 8'h01 after the wrap from 8'h80.
    for (int s = 0; s < 9; s++) begin
      e = 8'h01 << (s % 8);
      for (int c = 0; c < 16; c++) begin
        vectors++;
        if (obs8 !== {e, 3'(s % 8), 1'b1, 1'b0, 1'b0}) begin
          miscompares++; $display("FAIL scan step%0d cyc%0d got %h exp %h", s, c, obs8, {e, 3'(s % 8), 1'b1, 1'b0, 1'b0});
        end
        tick();
      end
    end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (oh8 !== 8'h02) begin miscompares++; $display("FAIL scan_midstep cyc%0d got %h exp %h", c, oh8, 8'h02); end
      tick();
    end
    ms8 = 1'b0;
    tick();
    vectors++;
    if (obs8 !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL scan_abort got %h exp %h", obs8, {8'h00, 3'd0, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_illegal;
    c6 = 3'd6; v6 = 1'b1;
    tick(); v6 = 1'b0;
    vectors++;
    if (obs6 !== {6'h00, 3'd0, 1'b0, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL illegal6 got %h exp %h", obs6, {6'h00, 3'd0, 1'b0, 1'b1, 1'b1});
    end
    tick(); tick();
    vectors++;
    if (err6 !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b exp %b", err6, 1'b1); end
    c6 = 3'd3; v6 = 1'b1;
    tick(); v6 = 1'b0;
    vectors++;
    if (obs6 !== {6'h08, 3'd3, 1'b1, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL legal_after_err got %h exp %h", obs6, {6'h08, 3'd3, 1'b1, 1'b0, 1'b1});
    end
    vectors++;
    if (err8 !== 1'b0) begin miscompares++; $display("FAIL err8_clean got %b exp %b", err8, 1'b0); end
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_reset_abort;
    c8 = 3'd3; v8 = 1'b1;
    tick(); v8 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (obs8 !== 14'h0) begin miscompares++; $display("FAIL rst_hold got %h exp %h", obs8, 14'h0); end
    vectors++;
    if (obs6 !== 12'h0) begin miscompares++; $display("FAIL rst_clears_err got %h exp %h", obs6, 12'h0); end
    rst = 1'b0;
    ms8 = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if (obs8 !== {8'h01, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL scan_before_rst got %h exp %h", obs8, {8'h01, 3'd0, 1'b1, 1'b0, 1'b0});
    end
    rst = 1'b1; ms8 = 1'b0;
    tick();
    vectors++;
    if (obs8 !== 14'h0) begin miscompares++; $display("FAIL rst_scan got %h exp %h", obs8, 14'h0); end
    rst = 1'b0;
    tick();
    vectors++;
    if (obs8 !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL rst_scan_idle got %h exp %h", obs8, {8'h00, 3'd0, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_priority;
    c8 = 3'd1; v8 = 1'b1; ms8 = 1'b1;
    tick(); v8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs8 !== {8'h02, 3'd1, 1'b1, 1'b0, 1'b0}) begin
        miscompares++; $display("FAIL prio_hold cyc%0d got %h exp %h", k, obs8, {8'h02, 3'd1, 1'b1, 1'b0, 1'b0});
      end
      tick();
    end
    vectors++;
    if (obs8 !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL prio_idle got %h exp %h", obs8, {8'h00, 3'd0, 1'b0, 1'b1, 1'b0});
    end
    tick();
    vectors++;
    if (obs8 !== {8'h01, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL prio_scan got %h exp %h", obs8, {8'h01, 3'd0, 1'b1, 1'b0, 1'b0});
    end
    ms8 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_hold();
    test_back_to_back();
    test_scan();
    test_illegal();
    test_reset_abort();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
